// File: rtl/mips_reg_dump.sv
// Post-halt register-file dump: walks FIRST_REG..LAST_REG and
// streams each value on valid/ready with a running XOR checksum.
module mips_reg_dump #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted_in,
  output logic [4:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic [DATA_W-1:0] checksum,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_e;

  state_e            state_q;
  logic              halted_q;
  logic [4:0]        idx_q;
  logic              valid_q;
  logic [4:0]        didx_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic [DATA_W-1:0] csum_q;
  logic              abort_q;

  logic              start_d;
  logic              fire_d;
  logic [4:0]        idx_d;

  assign start_d = halted_in & ~halted_q;
  assign fire_d  = valid_q & dump_ready;
  assign idx_d   = idx_q + 5'd1;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      idx_q    <= FIRST_A;
      valid_q  <= 1'b0;
      didx_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      csum_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      halted_q <= halted_in;
      abort_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q <= S_READ;
            idx_q   <= FIRST_A;
            csum_q  <= '0;
          end
        end
        S_READ: begin
          if (!halted_in) begin
            state_q <= S_IDLE;
            abort_q <= 1'b1;
          end else begin
            data_q  <= reg_rd_data;
            didx_q  <= idx_q;
            valid_q <= 1'b1;
            last_q  <= (idx_q == LAST_A);
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          // a word accepted on the abort edge still counts
          if (fire_d) begin
            csum_q  <= csum_q ^ data_q;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
          if (!halted_in) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            abort_q <= 1'b1;
          end else if (fire_d) begin
            if (last_q) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_d;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          if (!halted_in) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign reg_rd_addr = idx_q;
  assign dump_valid  = valid_q;
  assign dump_idx    = didx_q;
  assign dump_data   = data_q;
  assign dump_last   = last_q;
  assign checksum    = csum_q;
  assign busy        = (state_q == S_READ) || (state_q == S_HOLD);
  assign done        = (state_q == S_DONE);
  assign aborted     = abort_q;

endmodule

// File: tb/tb_mips_reg_dump.sv
// Scoreboard bench for mips_reg_dump: expected words queued by
// stimulus, popped and compared by a monitor on each handshake.
module tb_mips_reg_dump;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk1;
  logic        rst;
  logic        halted_in;
  logic        dump_ready;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_last;
  logic [31:0] checksum;
  logic        busy;
  logic        done;
  logic        aborted;

  logic        halted5;
  logic        ready5;
  logic [4:0]  rd_addr5;
  logic [31:0] rd_data5;
  logic        valid5;
  logic [4:0]  idx5;
  logic [31:0] data5;
  logic        last5;
  logic [31:0] csum5;
  logic        busy5;
  logic        done5;
  logic        abort5;

  logic [31:0] rf [32];
  word_t       q  [$];
  word_t       q5 [$];
  int          vectors = 0;
  int          errs    = 0;

  assign reg_rd_data = rf[reg_rd_addr];
  assign rd_data5    = rf[rd_addr5];

  mips_reg_dump #(
    .FIRST_REG(1), .LAST_REG(4), .DATA_W(32)
  ) dut (
    .clk1(clk1), .rst(rst), .halted_in(halted_in),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last), .checksum(checksum),
    .busy(busy), .done(done), .aborted(aborted)
  );

  mips_reg_dump #(
    .FIRST_REG(3), .LAST_REG(3), .DATA_W(32)
  ) dut5 (
    .clk1(clk1), .rst(rst), .halted_in(halted5),
    .reg_rd_addr(rd_addr5), .reg_rd_data(rd_data5),
    .dump_valid(valid5), .dump_ready(ready5),
    .dump_idx(idx5), .dump_data(data5),
    .dump_last(last5), .checksum(csum5),
    .busy(busy5), .done(done5), .aborted(abort5)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic push(input logic [4:0] i, input logic [31:0] d,
                      input logic l);
    word_t w;
    w.idx = i;
    w.data = d;
    w.last = l;
    q.push_back(w);
  endtask

  task automatic push_full(input logic [31:0] r4);
    push(5'd1, 32'd1, 1'b0);
    push(5'd2, 32'd2, 1'b0);
    push(5'd3, 32'd1, 1'b0);
    push(5'd4, r4, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!dump_valid && n < 20) begin
      step();
      n++;
    end
    chk("wait_valid", {31'd0, dump_valid}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  task automatic idle_out();
    halted_in = 1'b0;
    step();
    step();
  endtask

  // monitor: every accepted word must match the head of its queue
  always @(negedge clk1) begin
    if (!rst) begin
      if (dump_valid && dump_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", {27'd0, dump_idx}, 32'hFFFF_FFFF);
        end else begin
          word_t w;
          w = q.pop_front();
          chk("word_idx", {27'd0, dump_idx}, {27'd0, w.idx});
          chk("word_data", dump_data, w.data);
          chk("word_last", {31'd0, dump_last}, {31'd0, w.last});
        end
      end
      if (valid5 && ready5) begin
        if (q5.size() == 0) begin
          chk("unexpected_word5", {27'd0, idx5}, 32'hFFFF_FFFF);
        end else begin
          word_t w;
          w = q5.pop_front();
          chk("word5_idx", {27'd0, idx5}, {27'd0, w.idx});
          chk("word5_data", data5, w.data);
          chk("word5_last", {31'd0, last5}, {31'd0, w.last});
        end
      end
    end
  end

  initial begin
    word_t w5;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd1;
    rf[2] = 32'd2;
    rf[3] = 32'd1;
    rf[4] = 32'd0;
    rst = 1'b1;
    halted_in = 1'b0;
    dump_ready = 1'b0;
    halted5 = 1'b0;
    ready5 = 1'b1;
    step();
    step();
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_abort", {31'd0, aborted}, 32'd0);
    chk("rst_csum", checksum, 32'd0);
    chk("rst_addr", {27'd0, reg_rd_addr}, 32'd1);
    chk("rst_addr5", {27'd0, rd_addr5}, 32'd3);
    rst = 1'b0;
    step();

    // full dump, ready always high, first-word latency
    dump_ready = 1'b1;
    push_full(32'd0);
    halted_in = 1'b1;
    step();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_novalid", {31'd0, dump_valid}, 32'd0);
    step();
    chk("t1_valid", {31'd0, dump_valid}, 32'd1);
    chk("t1_first_idx", {27'd0, dump_idx}, 32'd1);
    wait_done();
    chk("t1_csum", checksum, 32'd2);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_q_empty", q.size(), 32'd0);

    // leave DONE, then a second dump with R4=7
    halted_in = 1'b0;
    step();
    chk("t6_done_clr", {31'd0, done}, 32'd0);
    chk("t6_csum_frozen", checksum, 32'd2);
    step();
    rf[4] = 32'd7;
    push_full(32'd7);
    halted_in = 1'b1;
    wait_done();
    chk("t6_csum", checksum, 32'd5);
    chk("t6_q_empty", q.size(), 32'd0);
    rf[4] = 32'd0;

    // backpressure on idx2
    idle_out();
    dump_ready = 1'b0;
    push_full(32'd0);
    halted_in = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      wait_valid();
      if (w == 2) begin
        for (int k = 0; k < 3; k++) begin
          step();
          chk("t2_hold_valid", {31'd0, dump_valid}, 32'd1);
          chk("t2_hold_idx", {27'd0, dump_idx}, 32'd2);
          chk("t2_hold_data", dump_data, 32'd2);
        end
      end
      dump_ready = 1'b1;
      step();
      dump_ready = 1'b0;
    end
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_csum", checksum, 32'd2);
    chk("t2_q_empty", q.size(), 32'd0);

    // abort while idx3 is held
    idle_out();
    push(5'd1, 32'd1, 1'b0);
    push(5'd2, 32'd2, 1'b0);
    halted_in = 1'b1;
    for (int w = 1; w <= 2; w++) begin
      wait_valid();
      dump_ready = 1'b1;
      step();
      dump_ready = 1'b0;
    end
    wait_valid();
    chk("t3_idx3", {27'd0, dump_idx}, 32'd3);
    halted_in = 1'b0;
    step();
    chk("t3_aborted", {31'd0, aborted}, 32'd1);
    chk("t3_valid", {31'd0, dump_valid}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_done", {31'd0, done}, 32'd0);
    chk("t3_csum", checksum, 32'd3);
    step();
    chk("t3_pulse_end", {31'd0, aborted}, 32'd0);
    chk("t3_q_empty", q.size(), 32'd0);

    // reset during READ of idx2; halt still high restarts from idx1
    dump_ready = 1'b1;
    push(5'd1, 32'd1, 1'b0);
    halted_in = 1'b1;
    begin
      int n = 0;
      while (!(busy && !dump_valid && reg_rd_addr == 5'd2) && n < 20) begin
        step();
        n++;
      end
    end
    chk("t4_read2", {27'd0, reg_rd_addr}, 32'd2);
    rst = 1'b1;
    step();
    chk("t4_valid", {31'd0, dump_valid}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_abort", {31'd0, aborted}, 32'd0);
    chk("t4_csum", checksum, 32'd0);
    chk("t4_data", dump_data, 32'd0);
    chk("t4_addr", {27'd0, reg_rd_addr}, 32'd1);
    push_full(32'd0);
    rst = 1'b0;
    wait_done();
    chk("t4_csum_final", checksum, 32'd2);
    chk("t4_q_empty", q.size(), 32'd0);

    // single-register dump on the FIRST=LAST=3 instance
    rf[3] = 32'hDEAD_BEEF;
    w5.idx = 5'd3;
    w5.data = 32'hDEAD_BEEF;
    w5.last = 1'b1;
    q5.push_back(w5);
    halted5 = 1'b1;
    begin
      int n = 0;
      while (!done5 && n < 20) begin
        step();
        n++;
      end
    end
    chk("t5_done", {31'd0, done5}, 32'd1);
    chk("t5_csum", csum5, 32'hDEAD_BEEF);
    chk("t5_q_empty", q5.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
